// File: rtl/POLI_types_pkg.sv
// Shared POLI types: word size and APB master bridge definitions.
package POLI_types_pkg;

  localparam int WORD_SIZE = 32;
  localparam int APB_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_master_state_t;

endpackage

// File: rtl/apb_master_if.sv
// Host-side request/response bundle for the APB master bridge.
interface apb_master_if #(
  parameter int W = POLI_types_pkg::WORD_SIZE
);

  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [W-1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         rsp_valid;
  logic [W-1:0] rsp_rdata;
  logic         rsp_error;

  modport host (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport bridge (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding request/response port to APB3 master,
// with a bounded ACCESS-phase timeout that yields an error response.
module apb_master_bridge #(
  parameter int WORD_SIZE      = POLI_types_pkg::WORD_SIZE,
  parameter int TIMEOUT_CYCLES = POLI_types_pkg::APB_TIMEOUT_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 rsp_error,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [WORD_SIZE-1:0] PADDR,
  output logic [WORD_SIZE-1:0] PWDATA,
  input  logic [WORD_SIZE-1:0] PRDATA,
  input  logic                 PREADY
);

  import POLI_types_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  apb_master_state_t state_q, state_d;

  logic                 wr_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 err_q;
  logic [CW-1:0]        cnt_q;
  logic                 expired;

  assign expired = (cnt_q == LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus strobes come only from the state register.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = SETUP;
      end
      SETUP: begin
        PSEL    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || expired) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && req_valid) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_write ? req_wdata : '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !PREADY && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // PREADY wins over expiry on the last permitted cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == ACCESS) begin
      if (PREADY) begin
        rdata_q <= wr_q ? '0 : PRDATA;
        err_q   <= 1'b0;
      end else if (expired) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign PWRITE    = wr_q;
  assign PADDR     = addr_q;
  assign PWDATA    = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus random transfers against an arithmetic model of
// the bridge timing (SETUP, ACCESS with waits/timeout, RESP).
module tb_apb_master_bridge;

  localparam int W  = 32;
  localparam int TO = 16;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [W-1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         rsp_valid;
  logic [W-1:0] rsp_rdata;
  logic         rsp_error;
  logic         PSEL;
  logic         PENABLE;
  logic         PWRITE;
  logic [W-1:0] PADDR;
  logic [W-1:0] PWDATA;
  logic [W-1:0] PRDATA;
  logic         PREADY;

  int n_chk  = 0;
  int n_fail = 0;

  apb_master_bridge #(
    .WORD_SIZE(W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // waits = ACCESS cycles with PREADY low before it rises;
  // waits >= TO means the slave never answers in time.
  task automatic xfer(input logic w,
                      input logic [W-1:0] a,
                      input logic [W-1:0] d,
                      input int waits,
                      input logic [W-1:0] prd,
                      input bit keep);
    int cyc;
    int acc;
    bit exp_err;
    int exp_acc;
    logic [W-1:0] exp_rd;
    exp_err = (waits >= TO);
    exp_acc = exp_err ? TO : waits + 1;
    exp_rd  = (exp_err || w) ? '0 : prd;

    chk("idle_ready", {31'd0, req_ready}, 1);
    chk("idle_psel", {31'd0, PSEL}, 0);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    PREADY    = 1'($urandom);
    PRDATA    = $urandom;
    cyc = 0;
    @(negedge CLK); cyc++;

    chk("setup_psel", {31'd0, PSEL}, 1);
    chk("setup_penable", {31'd0, PENABLE}, 0);
    chk("setup_paddr", PADDR, a);
    chk("setup_pwrite", {31'd0, PWRITE}, {31'd0, w});
    chk("setup_pwdata", PWDATA, w ? d : '0);
    chk("setup_ready", {31'd0, req_ready}, 0);
    if (keep) begin
      req_write = ~w;
      req_addr  = $urandom;
      req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    PREADY = 1'b1;
    @(negedge CLK); cyc++;

    acc = 0;
    while (rsp_valid !== 1'b1 && acc < 40) begin
      acc++;
      chk("acc_psel", {31'd0, PSEL}, 1);
      chk("acc_penable", {31'd0, PENABLE}, 1);
      chk("acc_paddr", PADDR, a);
      chk("acc_pwdata", PWDATA, w ? d : '0);
      PREADY = ((acc - 1) >= waits);
      PRDATA = PREADY ? prd : $urandom;
      @(negedge CLK); cyc++;
    end

    chk("rsp_valid", {31'd0, rsp_valid}, 1);
    chk("rsp_access_cycles", acc, exp_acc);
    chk("rsp_latency", cyc, exp_acc + 2);
    chk("rsp_error", {31'd0, rsp_error}, {31'd0, exp_err});
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_psel", {31'd0, PSEL}, 0);
    chk("rsp_penable", {31'd0, PENABLE}, 0);
    PREADY = 1'b0;
    PRDATA = $urandom;
    @(negedge CLK);

    chk("post_valid", {31'd0, rsp_valid}, 0);
    chk("post_rdata_hold", rsp_rdata, exp_rd);
    chk("post_error_hold", {31'd0, rsp_error}, {31'd0, exp_err});
    chk("post_psel", {31'd0, PSEL}, 0);
  endtask

  initial begin
    bit seen;
    bit keep;
    nRST      = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    #12;
    chk("rst_psel", {31'd0, PSEL}, 0);
    chk("rst_penable", {31'd0, PENABLE}, 0);
    chk("rst_pwrite", {31'd0, PWRITE}, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_error", {31'd0, rsp_error}, 0);
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    xfer(1'b1, 32'h0000_0004, 32'hA5A5_1234, 0, 32'h1111_2222, 1'b0);
    xfer(1'b0, 32'h0000_0008, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
    xfer(1'b0, 32'h0000_000C, 32'h0, TO, 32'hCAFE_0001, 1'b0);
    xfer(1'b0, 32'h0000_0010, 32'h0, TO - 1, 32'h0000_0055, 1'b0);
    xfer(1'b1, 32'h0000_0014, 32'h7777_8888, TO - 1, 32'h0, 1'b0);

    // Reset dropped in the middle of ACCESS.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0100;
    PREADY    = 1'b0;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("arst_psel", {31'd0, PSEL}, 0);
    chk("arst_penable", {31'd0, PENABLE}, 0);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("arst_req_ready", {31'd0, req_ready}, 1);
    @(negedge CLK);
    nRST   = 1'b1;
    PREADY = 1'b1;
    seen   = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0) seen = 1'b1;
    end
    chk("arst_quiet", {31'd0, seen}, 0);
    chk("arst_ready_after", {31'd0, req_ready}, 1);
    PREADY = 1'b0;

    // req_valid held high across two back-to-back transfers.
    xfer(1'b1, 32'h0000_0020, 32'h0102_0304, 1, 32'h0, 1'b1);
    xfer(1'b0, 32'h0000_0024, 32'h0, 0, 32'h5A5A_A5A5, 1'b0);

    for (int i = 0; i < 24; i++) begin
      keep = (i < 23) && ($urandom_range(0, 1) == 1);
      xfer(1'($urandom), $urandom, $urandom,
           $urandom_range(0, TO + 2), $urandom, keep);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Upstream neighbour of the POLI top level. Converts a simple single-outstanding request/response port into APB3 transfers (SETUP/ACCESS phases, PREADY wait states) that drive the POLI PSEL/PENABLE/PADDR/PWDATA/PWRITE inputs and capture PRDATA. It lets a host-side sequencer or an on-chip test controller program the control register and run CRC jobs without hand-timing the bus. A bounded-timeout counter turns a hung slave into an error response.

Parameters:
WORD_SIZE, 32, data and address width; taken from POLI_types_pkg.
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles without PREADY before an error response; legal range ≥1.

Ports:
CLK  input  1  system clock.
nRST  input  1  asynchronous, active-low reset.
req_valid  input  1  host request present.
req_ready  output  1  bridge can accept a request this cycle.
req_write  input  1  1=write, 0=read.
req_addr  input  WORD_SIZE  target APB address.
req_wdata  input  WORD_SIZE  write data.
rsp_valid  output  1  one-cycle response strobe.
rsp_rdata  output  WORD_SIZE  read data; 0 for writes and errors.
rsp_error  output  1  1 = transfer timed out.
PSEL  output  1  APB select.
PENABLE  output  1  APB enable.
PWRITE  output  1  APB direction.
PADDR  output  WORD_SIZE  APB address.
PWDATA  output  WORD_SIZE  APB write data.
PRDATA  input  WORD_SIZE  APB read data.
PREADY  input  1  APB ready / wait-state control.

Behaviour:
- One clock (CLK). Reset is asynchronous, active-low (nRST). All state elements clear immediately on nRST=0.
- Reset values: state=IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata and rsp_error are all 0. req_ready=1.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid=1 at a clock edge, latch req_write, req_addr and req_wdata, then go to SETUP.
  - A latched read drives PWDATA=0.
- SETUP:
  - PSEL=1, PENABLE=0. PADDR, PWRITE and PWDATA come from the latched registers.
  - PREADY is ignored.
  - Unconditionally go to ACCESS after one cycle. Clear the timeout counter.
- ACCESS:
  - PSEL=1, PENABLE=1. Address, data and direction stay stable.
  - If PREADY=1: capture PRDATA into rsp_rdata (reads only; writes load 0), set rsp_error=0, go to RESP.
  - Otherwise increment the counter.
  - If the counter equals TIMEOUT_CYCLES-1 and PREADY=0: set rsp_rdata=0, rsp_error=1, go to RESP.
  - If PREADY=1 arrives on the final permitted cycle, success takes precedence over timeout.
- RESP:
  - rsp_valid=1 for exactly one cycle. No backpressure; the host must sample it.
  - PSEL=0 and PENABLE=0.
  - Go to IDLE. rsp_rdata and rsp_error hold until the next response.
- req_ready=0 in SETUP, ACCESS and RESP. req_valid in those states is ignored and not queued.
- Minimum latency, from accepting edge to rsp_valid high: 3 cycles with zero wait states. Throughput is one transfer per 4 cycles.
- PSEL and PENABLE are decoded from the state register only. There is no combinational path from req_* to APB outputs.
- Counter width is $clog2(TIMEOUT_CYCLES+1). With TIMEOUT_CYCLES=1, ACCESS lasts exactly one cycle.
- If nRST asserts mid-transfer, the bus drops to idle immediately and no response is generated. The host must reissue the request.

Decomposition:
- POLI_types_pkg additions:
  - apb_master_state_t enum {IDLE, SETUP, ACCESS, RESP}.
  - APB_TIMEOUT_DEFAULT = 16.
- WORD_SIZE is reused from POLI_types_pkg.
- Add an apb_master_if.vh interface bundling the req/rsp signals, with host and bridge modports. It matches how the other POLI blocks attach.
- No sub-module. The FSM, latches and counter form a single module.

Test Plan:
1. Write, zero wait: req addr=0x0000_0004, wdata=0xA5A5_1234, PREADY held 1 → SETUP then ACCESS carry PADDR=0x4, PWRITE=1, PWDATA=0xA5A5_1234; rsp_valid 3 cycles after accept; rsp_error=0; rsp_rdata=0.
2. Read, 2 wait states: PREADY low for 2 ACCESS cycles then high with PRDATA=0xDEAD_BEEF → ACCESS lasts 3 cycles; rsp_rdata=0xDEAD_BEEF; rsp_error=0.
3. Timeout: PREADY never asserts, TIMEOUT_CYCLES=16 → exactly 16 ACCESS cycles, then rsp_valid=1, rsp_error=1, rsp_rdata=0; PSEL=0 next cycle.
4. Boundary precedence: PREADY=1 on the 16th ACCESS cycle with PRDATA=0x0000_0055 → success, rsp_error=0, rsp_rdata=0x55.
5. Reset mid-ACCESS: drop nRST during ACCESS → PSEL, PENABLE and rsp_valid go 0 asynchronously; req_ready=1 after release; no rsp_valid.
6. Back-to-back and ignored request: hold req_valid high continuously with two different requests → second is accepted only in IDLE after RESP; requests presented while busy produce no bus activity; PSEL is low at least one cycle between transfers.
